// File: rtl/spi_sdi_frame_rx.sv
// SPI-slave (mode 0) deserializer for the MCU->CPLD command link.
// Synchronizes the SPI pins into clk and publishes each good 64-bit frame as cmd/addr/data.
module spi_sdi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic [CMD_WIDTH-1:0]  spi_cmd_r,
  output logic [ADDR_WIDTH-1:0] spi_addr_r,
  output logic [DATA_WIDTH-1:0] spi_data_r,
  output logic                  spi_data_valid_r,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int FRAME_BITS = CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int FLUSH_W    = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(FRAME_BITS + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q,   cs_hist_d;
  logic [FLUSH_W-1:0]     flush_q,     flush_d;

  state_e                 state_q,     state_d;
  logic [FRAME_BITS-1:0]  shift_q,     shift_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [CMD_WIDTH-1:0]   cmd_q,       cmd_d;
  logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]  data_q,      data_d;
  logic                   valid_q,     valid_d;
  logic                   err_q,       err_d;
  logic                   busy_q,      busy_d;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, cs_rise, cs_fall;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  // The chain resets to "deselected", so a cs_n held low across reset would look like a
  // fresh fall once the pin value flushes through; falls are masked until that is over.
  assign cs_fall   = ~cs_s & cs_hist_q & (flush_q == FLUSH_DONE);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    flush_d     = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 1'b1;
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = ~cs_s;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Deselect wins over a coincident sclk edge; the pulses land in the DONE cycle.
        if (cs_rise) begin
          state_d = ST_DONE;
          if (cnt_q == CNT_FULL) begin
            cmd_d   = shift_q[FRAME_BITS-1 -: CMD_WIDTH];
            addr_d  = shift_q[DATA_WIDTH +: ADDR_WIDTH];
            data_d  = shift_q[DATA_WIDTH-1:0];
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!resetn) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      flush_q     <= '0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_cmd_r        = cmd_q;
  assign spi_addr_r       = addr_q;
  assign spi_data_r       = data_q;
  assign spi_data_valid_r = valid_q;
  assign frame_err        = err_q;
  assign rx_busy          = busy_q;

endmodule

// File: tb/tb_spi_sdi_frame_rx.sv
// Bench for spi_sdi_frame_rx: 100 MHz clk, 10 MHz mode-0 SPI master, frame-level reference model.
`timescale 1ns/1ps
module tb_spi_sdi_frame_rx;

  logic        clk;
  logic        resetn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic [15:0] spi_cmd_r;
  logic [7:0]  spi_addr_r;
  logic [39:0] spi_data_r;
  logic        spi_data_valid_r;
  logic        frame_err;
  logic        rx_busy;

  spi_sdi_frame_rx #(
    .SYNC_STAGES(2),
    .CMD_WIDTH  (16),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (40)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .spi_sclk        (spi_sclk),
    .spi_mosi        (spi_mosi),
    .spi_cs_n        (spi_cs_n),
    .spi_cmd_r       (spi_cmd_r),
    .spi_addr_r      (spi_addr_r),
    .spi_data_r      (spi_data_r),
    .spi_data_valid_r(spi_data_valid_r),
    .frame_err       (frame_err),
    .rx_busy         (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the last good frame as the 64-bit MSB-first bit stream that was sent.
  logic [63:0] exp_word = '0;

  // Monitor: pulse counters, received payloads in order, and pulse-rule violations.
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  int          rule_viol = 0;
  logic        busy_seen = 1'b0;
  logic        prev_v    = 1'b0;
  logic        prev_e    = 1'b0;
  logic [63:0] got_q[$];

  always @(negedge clk) begin
    if (spi_data_valid_r) begin
      valid_cnt++;
      got_q.push_back({spi_cmd_r, spi_addr_r, spi_data_r});
    end
    if (frame_err) err_cnt++;
    if (spi_data_valid_r && frame_err) rule_viol++;
    if (spi_data_valid_r && prev_v) rule_viol++;
    if (frame_err && prev_e) rule_viol++;
    if (rx_busy) busy_seen = 1'b1;
    prev_v = spi_data_valid_r;
    prev_e = frame_err;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Master shifts n bits MSB-first from w; bits past 64 are random filler.
  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 64) ? w[63-i] : 1'($urandom);
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] w, input int n, output int dv, output int de);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    spi_cs_n = 1'b0;
    #50;
    shift_bits(w, n);
    #50 spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    dv = valid_cnt - v0;
    de = err_cnt - e0;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r, frame_err, rx_busy} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h addr=%h data=%h v=%b e=%b busy=%b, required all 0",
               spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r, frame_err, rx_busy);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int dv, de;
    logic [63:0] w;
    w = {16'h1234, 8'h05, 40'hA5_0000_0003};
    busy_seen = 1'b0;
    send_frame(w, 64, dv, de);
    exp_word = w;
    checks++;
    if (dv !== 1 || de !== 0) begin
      errors++;
      $display("FAIL good_pulses: got valid=%0d err=%0d, required valid=1 err=0", dv, de);
    end
    checks++;
    if (spi_cmd_r !== 16'h1234 || spi_addr_r !== 8'h05 || spi_data_r !== 40'hA500000003) begin
      errors++;
      $display("FAIL good_payload: got %h/%h/%h, required 1234/05/a500000003",
               spi_cmd_r, spi_addr_r, spi_data_r);
    end
    checks++;
    if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL good_busy: got seen=%b after=%b, required seen=1 after=0", busy_seen, rx_busy);
    end
  endtask

  task automatic test_bad_length(input string name, input int n);
    int dv, de;
    send_frame(64'($urandom) << 32 | 64'($urandom), n, dv, de);
    checks++;
    if (dv !== 0 || de !== 1) begin
      errors++;
      $display("FAIL %s_pulses: got valid=%0d err=%0d, required valid=0 err=1", name, dv, de);
    end
    checks++;
    if ({spi_cmd_r, spi_addr_r, spi_data_r} !== exp_word) begin
      errors++;
      $display("FAIL %s_hold: got %h, required %h", name, {spi_cmd_r, spi_addr_r, spi_data_r}, exp_word);
    end
  endtask

  task automatic test_back_to_back(input string name, input int gap_ns);
    logic [63:0] w1, w2;
    int v0;
    w1 = {32'($urandom), 32'($urandom)};
    w2 = {16'h00FF, 8'h02, 40'h1};
    got_q.delete();
    v0 = valid_cnt;
    spi_cs_n = 1'b0;
    #50;
    shift_bits(w1, 64);
    #50 spi_cs_n = 1'b1;
    #(gap_ns) spi_cs_n = 1'b0;
    #50;
    shift_bits(w2, 64);
    #50 spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    exp_word = w2;
    checks++;
    if (valid_cnt - v0 !== 2 || got_q.size() !== 2) begin
      errors++;
      $display("FAIL %s_count: got %0d valid pulses, required 2", name, valid_cnt - v0);
    end else begin
      checks++;
      if (got_q[0] !== w1 || got_q[1] !== w2) begin
        errors++;
        $display("FAIL %s_order: got %h then %h, required %h then %h", name, got_q[0], got_q[1], w1, w2);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv, de, v0, e0;
    logic [63:0] w;
    w  = {32'($urandom), 32'($urandom)};
    v0 = valid_cnt;
    e0 = err_cnt;
    spi_cs_n = 1'b0;
    #50;
    shift_bits(w, 31);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r, frame_err, rx_busy} !== 67'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got cmd=%h addr=%h data=%h v=%b e=%b busy=%b, required all 0",
               spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r, frame_err, rx_busy);
    end
    resetn = 1'b1;
    exp_word = '0;
    shift_bits(w << 31, 33);
    #50 spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL midreset_pulses: got valid=%0d err=%0d, required 0 and 0", valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'd0) begin
      errors++;
      $display("FAIL midreset_hold: got %h, required 0", {spi_cmd_r, spi_addr_r, spi_data_r});
    end
    w = {32'($urandom), 32'($urandom)};
    send_frame(w, 64, dv, de);
    exp_word = w;
    checks++;
    if (dv !== 1 || de !== 0 || {spi_cmd_r, spi_addr_r, spi_data_r} !== w) begin
      errors++;
      $display("FAIL midreset_next: got valid=%0d err=%0d word=%h, required 1/0/%h",
               dv, de, {spi_cmd_r, spi_addr_r, spi_data_r}, w);
    end
  endtask

  task automatic test_ignored_traffic();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      spi_mosi = 1'($urandom);
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
    end
    repeat (12) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL ignored_pulses: got valid=%0d err=%0d busy_seen=%b, required 0/0/0",
               valid_cnt - v0, err_cnt - e0, busy_seen);
    end
    checks++;
    if ({spi_cmd_r, spi_addr_r, spi_data_r} !== exp_word) begin
      errors++;
      $display("FAIL ignored_hold: got %h, required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, exp_word);
    end
  endtask

  task automatic test_random_frames();
    int dv, de, n;
    logic [63:0] w;
    for (int k = 0; k < 16; k++) begin
      w = {32'($urandom), 32'($urandom)};
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : 64;
      send_frame(w, n, dv, de);
      if (n == 64) exp_word = w;
      checks++;
      if (dv !== ((n == 64) ? 1 : 0) || de !== ((n == 64) ? 0 : 1)) begin
        errors++;
        $display("FAIL random_pulses[%0d]: n=%0d got valid=%0d err=%0d", k, n, dv, de);
      end
      checks++;
      if ({spi_cmd_r, spi_addr_r, spi_data_r} !== exp_word) begin
        errors++;
        $display("FAIL random_word[%0d]: n=%0d got %h, required %h",
                 k, n, {spi_cmd_r, spi_addr_r, spi_data_r}, exp_word);
      end
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (rule_viol !== 0) begin
      errors++;
      $display("FAIL pulse_rules: got %0d violations (overlap or multi-cycle), required 0", rule_viol);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_length("short", 63);
    test_bad_length("long", 65);
    test_bad_length("zero", 0);
    test_back_to_back("b2b", 200);
    test_back_to_back("tight", 10);
    test_reset_mid_frame();
    test_ignored_traffic();
    test_random_frames();
    test_pulse_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sdi_frame_rx.md
Name: spi_sdi_frame_rx

Overview:
- SPI-slave deserializer for the MCU→CPLD command link.
- Samples the asynchronous SPI pins in the clk domain and assembles 64-bit write frames (cmd, addr, data).
- Presents each frame on the registered spi_cmd_r / spi_addr_r / spi_data_r / spi_data_valid_r bus, which is fanned out to every slot-card module.
- It is the producer end of the "spi sdi sets" interface that slot cards decode.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on spi_sclk, spi_mosi and spi_cs_n (minimum 2).
- CMD_WIDTH, 16, command field width.
- ADDR_WIDTH, 8, slot address field width.
- DATA_WIDTH, 40, data field width. Frame length FRAME_BITS = CMD_WIDTH+ADDR_WIDTH+DATA_WIDTH = 64.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous reset, active-low.
- spi_sclk  input  1  SPI clock from MCU, async, mode 0.
- spi_mosi  input  1  SPI data from MCU, async.
- spi_cs_n  input  1  SPI frame select from MCU, active-low, async.
- spi_cmd_r  output  CMD_WIDTH  command of last good frame.
- spi_addr_r  output  ADDR_WIDTH  address of last good frame.
- spi_data_r  output  DATA_WIDTH  data of last good frame.
- spi_data_valid_r  output  1  one-cycle pulse: new good frame on the bus.
- frame_err  output  1  one-cycle pulse: frame ended with bit count != FRAME_BITS.
- rx_busy  output  1  high while the synchronized cs_n is low.

Behaviour:
- Reset: when resetn=0 at a clk edge:
  - state=IDLE; shift register, bit counter and all outputs = 0.
  - Synchronizer flops load 1 for cs_n and 0 for sclk/mosi.
- Sampling: each input passes through SYNC_STAGES flops plus one history flop.
  - sclk_rise = sync & ~hist.
  - cs_fall / cs_rise are derived the same way.
  - MOSI is taken from the same synchronizer depth as SCLK, so data and clock stay aligned.
- Clock ratio: clk frequency >= 4x SCLK frequency. Behaviour is undefined below that ratio.
- Bit order: MSB first. Frame layout is cmd[15:0], then addr[7:0], then data[39:0].
  - After 64 bits: shift[63:48]=cmd, shift[47:40]=addr, shift[39:0]=data.
- Bit counter: 7 bits, saturates at FRAME_BITS+1 (65).
- States:
  - IDLE:
    - sclk edges are ignored.
    - On cs_fall: clear shift register and counter, go to SHIFT.
  - SHIFT:
    - On each sclk_rise: shift = {shift[62:0], mosi_sync}; counter++ (saturating).
    - On cs_rise: go to DONE.
    - If sclk_rise and cs_rise occur in the same cycle, the bit is ignored (the edge is taken as after deselect).
  - DONE (exactly one cycle):
    - If counter==64: load cmd/addr/data from the shift register and assert spi_data_valid_r for this one cycle.
    - Otherwise: assert frame_err for this one cycle; cmd/addr/data keep their previous values.
    - Next state is IDLE.
    - If cs_fall is seen during DONE, it is not lost: go directly to SHIFT with counter and shift register cleared.
- Latency: spi_data_valid_r is high in the cycle after the cycle in which cs_rise is detected.
  - From a cs_n pin rise set up before clk edge k, valid is high during cycle k+SYNC_STAGES+1 (+1 cycle for async sampling).
- Output hold: cmd/addr/data change only in DONE with a good count. They are stable while valid is high and until the next good frame.
- Validity rule: spi_data_valid_r and frame_err are never high together, and each is never high for more than one cycle.
- rx_busy = ~cs_n_sync (registered).
- Reset mid-frame: resetn=0 during SHIFT aborts the frame.
  - No valid and no frame_err.
  - After reset releases, a cs_n that is still low is not treated as a new frame. A fresh cs_fall is required.
- Short frame (<64 bits) or long frame (>64 bits, counter saturated) -> frame_err. The shift contents are discarded.
- Zero-bit frame (cs low then high with no sclk) -> frame_err.

Test Plan:
- Good frame:
  - Stimulus: clk=100 MHz, SCLK=10 MHz; send cmd=16'h1234, addr=8'h05, data=40'hA5_0000_0003, then raise cs_n.
  - Required: exactly one valid pulse; spi_cmd_r=16'h1234, spi_addr_r=8'h05, spi_data_r=40'hA500000003; frame_err stays 0.
- Short frame:
  - Stimulus: send 63 bits after a good frame.
  - Required: one frame_err pulse, no valid pulse; outputs still show the previous frame (16'h1234/8'h05/…).
- Long frame:
  - Stimulus: send 65 bits.
  - Required: one frame_err pulse, no valid pulse, outputs unchanged.
- Back-to-back frames:
  - Stimulus: two good frames with cs_n high for only 2 SCLK periods between them; frame 2 is cmd=16'h00FF, addr=8'h02, data=40'h1.
  - Required: two valid pulses, in order, with the correct payloads.
- Reset mid-frame:
  - Stimulus: assert resetn=0 for 3 cycles after bit 30; keep cs_n low and clocking, then raise cs_n.
  - Required: all outputs 0; no valid, no frame_err; the next complete frame is received correctly.
- Ignored traffic:
  - Stimulus: toggle SCLK/MOSI 100 times while cs_n is high.
  - Required: no valid, no frame_err, rx_busy=0, outputs unchanged.
